// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding
// and the sizing helper for the iteration counter.
package booth_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bits needed to hold a count from 0 up to n inclusive
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/registro_desp_n.sv
// W-bit register with parallel load, right shift with serial-in MSB, and
// asynchronous active-low clear. Load wins over shift.
module registro_desp_n #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic         en_s;

  assign en_s = load_i | shift_i;
  assign q_o  = q_q;

  // Storage: clear, then load or shift when enabled
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= '0;
    end else if (en_s) begin
      if (load_i) begin
        q_q <= d_i;
      end else begin
        q_q <= {sin_i, q_q[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential signed N x N radix-2 Booth multiplier: one add/sub-and-shift
// per cycle, N cycles per product, one-cycle done pulse.
module booth_mult_n
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] producto
);

  localparam int CW = cnt_width(N);

  state_t          state_q, state_d;
  logic [N:0]      a_q, a_d, m_q, sum_s;
  logic [N-1:0]    q_q;
  logic            q1_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  prod_q, prod_d;
  logic            busy_q, done_q;
  logic            load_s, calc_s, last_s;

  assign load_s = (state_q == ST_IDLE) && start;
  assign calc_s = (state_q == ST_CALC);
  assign last_s = calc_s && (cnt_q == CW'(1));

  // M is kept N+1 bits wide so that subtracting -2^(N-1) cannot overflow A
  always_comb begin
    sum_s = a_q;
    case ({q_q[0], q1_q})
      2'b01:   sum_s = a_q + m_q;
      2'b10:   sum_s = a_q - m_q;
      default: sum_s = a_q;
    endcase
  end

  // Next A is the arithmetic right shift of the add/sub result
  always_comb begin
    a_d = '0;
    if (load_s) begin
      a_d = '0;
    end else begin
      a_d = {sum_s[N], sum_s[N:1]};
    end
    prod_d = {a_d[N-1:0], sum_s[0], q_q[N-1:1]};
  end

  registro_desp_n #(.W(N + 1)) u_reg_a (
    .clk     (clk),
    .clr_n   (reset),
    .load_i  (load_s | calc_s),
    .shift_i (1'b0),
    .d_i     (a_d),
    .sin_i   (1'b0),
    .q_o     (a_q)
  );

  registro_desp_n #(.W(N)) u_reg_q (
    .clk     (clk),
    .clr_n   (reset),
    .load_i  (load_s),
    .shift_i (calc_s),
    .d_i     (multiplicador),
    .sin_i   (sum_s[0]),
    .q_o     (q_q)
  );

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CALC;
        else       state_d = ST_IDLE;
      end
      ST_CALC: begin
        if (cnt_q == CW'(1)) state_d = ST_DONE;
        else                 state_d = ST_CALC;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, multiplicand, q_1, counter, product and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (load_s) begin
        m_q   <= {multiplicando[N-1], multiplicando};
        q1_q  <= 1'b0;
        cnt_q <= CW'(N);
      end else if (calc_s) begin
        q1_q  <= q_q[0];
        cnt_q <= cnt_q - CW'(1);
      end
      if (last_s) begin
        prod_q <= prod_d;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign producto = prod_q;

endmodule
